// File: rtl/click_pkg.sv
// Shared definitions for the click-driven SDRAM demo sequencer.
// Provides the sequencer FSM state encoding, the pending-event codes exchanged
// between the event slot and the sequencer, and the default widths.
package click_pkg;

    localparam int unsigned DEF_HADDR_WIDTH   = 24;
    localparam int unsigned DEF_DATA_WIDTH    = 16;
    localparam int unsigned DEF_TIMEOUT_WIDTH = 8;
    localparam logic [15:0] DEF_PATTERN       = 16'hA5A5;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_WAIT = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_WAIT = 3'd4
    } state_e;

    typedef logic [1:0] ev_t;

    localparam ev_t EV_NONE = 2'd0;
    localparam ev_t EV_WR   = 2'd1;
    localparam ev_t EV_RD   = 2'd2;

endpackage

// File: rtl/click_event_slot.sv
// One-entry pending-event register between the click detector and the
// sequencer FSM. Merges single/double pulses (double wins), stores an event
// only when the slot is empty or being consumed this cycle, and raises a
// sticky overflow flag when an event has to be dropped.
//
// Ports:
//   clk_i       system clock
//   rst_i       asynchronous active-high reset
//   single_i    single-click pulse
//   double_i    double-click pulse
//   consume_i   sequencer takes the pending event this cycle
//   event_o     pending event code (EV_NONE / EV_WR / EV_RD)
//   overflow_o  sticky: an event was dropped
module click_event_slot
    import click_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic single_i,
    input  logic double_i,
    input  logic consume_i,
    output ev_t  event_o,
    output logic overflow_o
);

    ev_t  slot_q, slot_d;
    ev_t  new_ev;
    logic overflow_q, overflow_d;
    logic slot_free;

    always_comb begin
        new_ev = EV_NONE;
        if (double_i) begin
            new_ev = EV_RD;
        end else if (single_i) begin
            new_ev = EV_WR;
        end

        // A slot being consumed this cycle can accept the new event directly.
        slot_free  = (slot_q == EV_NONE) || consume_i;
        slot_d     = consume_i ? EV_NONE : slot_q;
        overflow_d = overflow_q;

        if (new_ev != EV_NONE) begin
            if (slot_free) begin
                slot_d = new_ev;
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            slot_q     <= EV_NONE;
            overflow_q <= 1'b0;
        end else begin
            slot_q     <= slot_d;
            overflow_q <= overflow_d;
        end
    end

    assign event_o    = slot_q;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/click_mem_sequencer.sv
// Turns single/double click pulses into SDRAM host transactions.
// A single click writes (count ^ PATTERN) to address count and advances count;
// a double click reads back the most recently written address, shows the word
// on the LEDs and flags a sticky mismatch if it differs from what was written.
// A per-state watchdog aborts stuck handshakes and sets a sticky timeout flag.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   single, double       click pulses (one cycle each)
//   wr_addr/wr_data      write request address/data (registered)
//   wr_enable            write request, held until busy rises
//   rd_addr/rd_enable    read request address / request (registered)
//   rd_data, rd_ready    read data and its valid pulse
//   busy                 controller busy; high while a request is accepted
//   leds                 last word read back
//   mismatch, timeout, overflow   sticky status flags
module click_mem_sequencer
    import click_pkg::*;
#(
    parameter int unsigned            HADDR_WIDTH   = DEF_HADDR_WIDTH,
    parameter int unsigned            DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0]  PATTERN       = DATA_WIDTH'(DEF_PATTERN),
    parameter int unsigned            TIMEOUT_WIDTH = DEF_TIMEOUT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   single,
    input  logic                   double,
    output logic [HADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0]  wr_data,
    output logic                   wr_enable,
    output logic [HADDR_WIDTH-1:0] rd_addr,
    output logic                   rd_enable,
    input  logic [DATA_WIDTH-1:0]  rd_data,
    input  logic                   rd_ready,
    input  logic                   busy,
    output logic [DATA_WIDTH-1:0]  leds,
    output logic                   mismatch,
    output logic                   timeout,
    output logic                   overflow
);

    // Expire as the count steps onto all-ones, i.e. after 2^W-1 cycles in a state.
    localparam logic [TIMEOUT_WIDTH-1:0] WD_LAST = ~TIMEOUT_WIDTH'(1);

    ev_t  pending;
    logic consume;
    logic wd_expire;

    state_e                   state_q, state_d;
    logic [HADDR_WIDTH-1:0]   wr_count_q, wr_count_d;
    logic [DATA_WIDTH-1:0]    last_data_q, last_data_d;
    logic [TIMEOUT_WIDTH-1:0] wd_q, wd_d;
    logic                     wr_en_q, wr_en_d;
    logic                     rd_en_q, rd_en_d;
    logic [HADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]    wr_data_q, wr_data_d;
    logic [HADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
    logic [DATA_WIDTH-1:0]    leds_q, leds_d;
    logic                     mismatch_q, mismatch_d;
    logic                     timeout_q, timeout_d;

    click_event_slot u_slot (
        .clk_i      (clk),
        .rst_i      (rst),
        .single_i   (single),
        .double_i   (double),
        .consume_i  (consume),
        .event_o    (pending),
        .overflow_o (overflow)
    );

    always_comb begin
        state_d     = state_q;
        wr_count_d  = wr_count_q;
        last_data_d = last_data_q;
        wr_en_d     = wr_en_q;
        rd_en_d     = rd_en_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        rd_addr_d   = rd_addr_q;
        leds_d      = leds_q;
        mismatch_d  = mismatch_q;
        timeout_d   = timeout_q;
        consume     = 1'b0;
        wd_expire   = (state_q != ST_IDLE) && (wd_q == WD_LAST);

        if (wd_expire) begin
            // Abort whatever handshake is stuck; an unaccepted write leaves wr_count alone.
            timeout_d = 1'b1;
            wr_en_d   = 1'b0;
            rd_en_d   = 1'b0;
            state_d   = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pending == EV_WR) begin
                        consume   = 1'b1;
                        state_d   = ST_WR_REQ;
                        wr_en_d   = 1'b1;
                        wr_addr_d = wr_count_q;
                        wr_data_d = DATA_WIDTH'(wr_count_q) ^ PATTERN;
                    end else if (pending == EV_RD) begin
                        consume   = 1'b1;
                        state_d   = ST_RD_REQ;
                        rd_en_d   = 1'b1;
                        rd_addr_d = (wr_count_q == '0) ? '0 : wr_count_q - 1'b1;
                    end
                end
                ST_WR_REQ: begin
                    if (busy) begin
                        wr_en_d     = 1'b0;
                        last_data_d = wr_data_q;
                        wr_count_d  = wr_count_q + 1'b1;
                        state_d     = ST_WR_WAIT;
                    end
                end
                ST_WR_WAIT: begin
                    if (!busy) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RD_REQ: begin
                    if (busy) begin
                        rd_en_d = 1'b0;
                        state_d = ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (rd_ready) begin
                        leds_d = rd_data;
                        // Nothing has been written yet, so there is no reference word.
                        if ((wr_count_q != '0) && (rd_data != last_data_q)) begin
                            mismatch_d = 1'b1;
                        end
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    wr_en_d = 1'b0;
                    rd_en_d = 1'b0;
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Watchdog restarts on every state entry and only runs outside IDLE.
        if ((state_d != state_q) || (state_q == ST_IDLE)) begin
            wd_d = '0;
        end else begin
            wd_d = wd_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wr_count_q  <= '0;
            last_data_q <= '0;
            wd_q        <= '0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rd_addr_q   <= '0;
            leds_q      <= '0;
            mismatch_q  <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_count_q  <= wr_count_d;
            last_data_q <= last_data_d;
            wd_q        <= wd_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            rd_addr_q   <= rd_addr_d;
            leds_q      <= leds_d;
            mismatch_q  <= mismatch_d;
            timeout_q   <= timeout_d;
        end
    end

    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign wr_enable = wr_en_q;
    assign rd_addr   = rd_addr_q;
    assign rd_enable = rd_en_q;
    assign leds      = leds_q;
    assign mismatch  = mismatch_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_click_mem_sequencer.sv
// Self-checking bench for click_mem_sequencer: a controller/memory model with a
// scoreboard of expected requests, a table of click scenarios, and hand-written
// sequences for overflow, watchdog and asynchronous reset.
module tb_click_mem_sequencer;

    localparam int HW = 24;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          single;
    logic          double;
    logic [HW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_enable;
    logic [HW-1:0] rd_addr;
    logic          rd_enable;
    logic [DW-1:0] rd_data;
    logic          rd_ready;
    logic          busy;
    logic [DW-1:0] leds;
    logic          mismatch;
    logic          timeout;
    logic          overflow;

    always #5 clk = ~clk;

    click_mem_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .single    (single),
        .double    (double),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_enable (wr_enable),
        .rd_addr   (rd_addr),
        .rd_enable (rd_enable),
        .rd_data   (rd_data),
        .rd_ready  (rd_ready),
        .busy      (busy),
        .leds      (leds),
        .mismatch  (mismatch),
        .timeout   (timeout),
        .overflow  (overflow)
    );

    typedef struct {
        bit            is_wr;
        logic [HW-1:0] addr;
        logic [DW-1:0] data;
    } txn_t;

    typedef struct {
        int            n_single;
        bit            both;
        bit            corrupt;
        logic [HW-1:0] rd_addr;
        logic [DW-1:0] leds;
        bit            mm;
    } vec_t;

    txn_t          exp_q[$];
    vec_t          vecs[6];
    logic [DW-1:0] mem[0:15];
    int            n_checks = 0;
    int            n_pass = 0;
    int            txn_done = 0;
    int            exp_count = 0;
    bit            model_on = 1'b1;
    bit            corrupt = 1'b0;
    bit            skip_leds = 1'b0;
    int            hold_cycles = 5;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic push_wr();
        txn_t t;
        t.is_wr = 1'b1;
        t.addr  = HW'(exp_count);
        t.data  = DW'(exp_count) ^ 16'hA5A5;
        exp_q.push_back(t);
        exp_count++;
    endtask

    task automatic push_rd(input logic [HW-1:0] addr, input logic [DW-1:0] data);
        txn_t t;
        t.is_wr = 1'b0;
        t.addr  = addr;
        t.data  = data;
        exp_q.push_back(t);
    endtask

    task automatic pulse(input bit s, input bit d);
        @(negedge clk);
        single = s;
        double = d;
        @(negedge clk);
        single = 1'b0;
        double = 1'b0;
    endtask

    task automatic wait_txn(input int target, input string name);
        int i;
        i = 0;
        while (txn_done < target && i < 300) begin
            @(negedge clk);
            i++;
        end
        check(name, 32'(txn_done >= target), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_count = 0;
        exp_q.delete();
    endtask

    // Controller + memory model: busy rises 3 cycles after a request is seen,
    // stays high hold_cycles cycles, then a read returns data with rd_ready.
    initial begin : ctrl_model
        txn_t          t;
        logic [DW-1:0] rdv;
        bit            is_wr;
        busy     = 1'b0;
        rd_ready = 1'b0;
        rd_data  = '0;
        rdv      = '0;
        forever begin
            @(negedge clk);
            if (model_on && !rst && (wr_enable || rd_enable)) begin
                is_wr = wr_enable;
                check("one_enable", 32'(wr_enable & rd_enable), 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_request", 32'd1, 32'd0);
                    t.is_wr = is_wr;
                    t.addr  = '0;
                    t.data  = '0;
                end else begin
                    t = exp_q.pop_front();
                end
                check("req_kind", 32'(is_wr), 32'(t.is_wr));
                if (is_wr) begin
                    check("wr_addr", 32'(wr_addr), 32'(t.addr));
                    check("wr_data", 32'(wr_data), 32'(t.data));
                end else begin
                    check("rd_addr", 32'(rd_addr), 32'(t.addr));
                end
                repeat (3) @(negedge clk);
                check("enable_held", 32'(is_wr ? wr_enable : rd_enable), 32'd1);
                busy = 1'b1;
                if (is_wr) mem[wr_addr[3:0]] = wr_data;
                else rdv = corrupt ? '0 : mem[rd_addr[3:0]];
                @(negedge clk);
                check("enable_dropped", 32'(wr_enable | rd_enable), 32'd0);
                repeat (hold_cycles - 1) @(negedge clk);
                busy = 1'b0;
                if (!is_wr) begin
                    rd_data  = rdv;
                    rd_ready = 1'b1;
                    @(negedge clk);
                    rd_ready = 1'b0;
                    rd_data  = '0;
                    if (!skip_leds) check("leds_after_read", 32'(leds), 32'(t.data));
                end
                txn_done++;
            end
        end
    end

    initial begin : guard
        #400000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin : main
        int base;
        int cnt;
        rst    = 1'b1;
        single = 1'b0;
        double = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = '0;

        // n_single, both, corrupt, rd_addr, leds, mismatch (starting from reset)
        vecs[0] = '{0, 1'b0, 1'b0, 24'd0, 16'hA5A5, 1'b0}; // no write yet: never a mismatch
        vecs[1] = '{2, 1'b0, 1'b0, 24'd1, 16'hA5A4, 1'b0};
        vecs[2] = '{0, 1'b1, 1'b0, 24'd1, 16'hA5A4, 1'b0}; // single&double = one read
        vecs[3] = '{1, 1'b0, 1'b1, 24'd2, 16'h0000, 1'b1};
        vecs[4] = '{0, 1'b0, 1'b0, 24'd2, 16'hA5A7, 1'b1}; // sticky after a good read
        vecs[5] = '{3, 1'b0, 1'b0, 24'd5, 16'hA5A0, 1'b1};

        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset then idle.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_outputs", 32'({wr_enable, rd_enable, mismatch, timeout, overflow,
                                       |leds, |wr_addr, |wr_data, |rd_addr}), 32'd0);
        end

        // Single click: write A5A5 @ 0.
        base = txn_done;
        push_wr();
        pulse(1'b1, 1'b0);
        wait_txn(base + 1, "single_write_done");

        // Table-driven click scenarios.
        do_reset();
        for (int v = 0; v < 6; v++) begin
            for (int s = 0; s < vecs[v].n_single; s++) begin
                base = txn_done;
                push_wr();
                pulse(1'b1, 1'b0);
                wait_txn(base + 1, "vec_write_done");
            end
            corrupt = vecs[v].corrupt;
            base = txn_done;
            push_rd(vecs[v].rd_addr, vecs[v].leds);
            pulse(vecs[v].both, 1'b1);
            wait_txn(base + 1, "vec_read_done");
            repeat (5) @(negedge clk);
            corrupt = 1'b0;
            check("vec_txn_count", 32'(txn_done), 32'(base + 1));
            check("vec_leds", 32'(leds), 32'(vecs[v].leds));
            check("vec_mismatch", 32'(mismatch), 32'(vecs[v].mm));
            check("vec_queue_empty", 32'(exp_q.size()), 32'd0);
        end

        // Overflow: consume+arrive on the same cycle is fine, a third event is dropped.
        do_reset();
        base = txn_done;
        push_wr();
        push_wr();
        @(negedge clk);
        single = 1'b1;
        @(negedge clk);
        single = 1'b1;
        @(negedge clk);
        check("no_overflow_on_consume", 32'(overflow), 32'd0);
        single = 1'b0;
        double = 1'b1;
        @(negedge clk);
        double = 1'b0;
        check("overflow_set", 32'(overflow), 32'd1);
        wait_txn(base + 2, "overflow_two_writes");
        repeat (30) @(negedge clk);
        check("overflow_only_two_txns", 32'(txn_done), 32'(base + 2));
        check("overflow_queue_empty", 32'(exp_q.size()), 32'd0);
        check("overflow_sticky", 32'(overflow), 32'd1);

        // Watchdog: busy never rises.
        do_reset();
        model_on = 1'b0;
        pulse(1'b1, 1'b0);
        cnt = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (timeout) break;
            if (wr_enable) cnt++;
        end
        check("timeout_set", 32'(timeout), 32'd1);
        check("timeout_wr_cycles", 32'(cnt), 32'd255);
        check("timeout_wr_dropped", 32'(wr_enable | rd_enable), 32'd0);
        model_on = 1'b1;
        // wr_count still 0 and FSM back in IDLE: next write goes to address 0.
        base = txn_done;
        push_wr();
        pulse(1'b1, 1'b0);
        wait_txn(base + 1, "post_timeout_write");

        // Reset in the middle of RD_WAIT.
        hold_cycles = 40;
        skip_leds = 1'b1;
        push_rd(24'd0, 16'hA5A5);
        pulse(1'b0, 1'b1);
        cnt = 0;
        while (!busy && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        check("rd_busy_seen", 32'(busy), 32'd1);
        repeat (3) @(negedge clk);
        check("pre_reset_timeout", 32'(timeout), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_outputs", 32'({wr_enable, rd_enable, mismatch, timeout, overflow,
                                          |leds, |wr_addr, |wr_data, |rd_addr}), 32'd0);
        repeat (45) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("after_reset_idle", 32'({wr_enable, rd_enable, timeout, |leds}), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
